// File: rtl/fir_result_reader.sv
// ---------------------------------------------------------------------------
// fir_result_reader
//
// Reads a finished FIR filter's result registers one index per cycle and
// streams the returned words out over a valid/ready interface. Reads are
// issued only when a FIFO slot is guaranteed for the returning word.
//
// Ports
//   clk        : single clock, all state updates on its rising edge
//   reset      : asynchronous, active-low reset
//   done       : filter finished; result registers readable while high
//   regAddr    : result register index driven to the filter
//   regData    : result word, valid RD_LAT cycles after the read issues
//   out_data   : streamed sample (head of the output FIFO)
//   out_valid  : out_data valid
//   out_ready  : consumer accepts when high together with out_valid
//   out_last   : high with the final sample of a run
//   busy       : a run is in progress (reading or draining)
//   abort_err  : sticky flag, done fell during a run
// ---------------------------------------------------------------------------
module fir_result_reader #(
    parameter int signalCount = 10,
    parameter int DATA_W      = 32,
    parameter int RD_LAT      = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              done,
    output logic [31:0]       regAddr,
    input  logic [DATA_W-1:0] regData,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              abort_err
);

    localparam int IDX_W = $clog2(signalCount + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int OCC_W = $clog2(FIFO_DEPTH + RD_LAT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(signalCount - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] HOLD  = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [IDX_W-1:0]      index_q, index_d;
    logic [31:0]           regAddr_q, regAddr_d;
    logic [RD_LAT-1:0]     tagValid_q, tagValid_d;
    logic [RD_LAT-1:0]     tagLast_q, tagLast_d;
    logic [DATA_W-1:0]     fifoMem_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] lastMem_q, lastMem_d;
    logic [PTR_W-1:0]      wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]      rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  abortErr_q, abortErr_d;

    logic                  abortNow;
    logic                  fifoEmpty;
    logic                  issue;
    logic                  push;
    logic                  pop;
    logic [OCC_W-1:0]      inFlight;
    logic [OCC_W-1:0]      occupancy;

    // Number of reads still travelling through the filter's read latency.
    always_comb begin
        inFlight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inFlight = inFlight + OCC_W'(tagValid_q[i]);
        end
    end

    // Handshake decode. A read only issues when every in-flight word plus
    // every buffered word still leaves a free FIFO slot, so a push can
    // never find the FIFO full. An abort blocks push, pop and the output.
    always_comb begin
        abortNow  = ((state_q == ISSUE) || (state_q == DRAIN)) && !done;
        fifoEmpty = (count_q == '0);
        occupancy = inFlight + OCC_W'(count_q);
        issue     = (state_q == ISSUE) && done && (occupancy < OCC_W'(FIFO_DEPTH));
        push      = tagValid_q[RD_LAT-1] && !abortNow;
        pop       = !fifoEmpty && out_ready && !abortNow;
    end

    // Run control: index/address generation, the tag shift registers that
    // mark when each read's data arrives, and the state transitions.
    always_comb begin
        state_d    = state_q;
        index_d    = index_q;
        regAddr_d  = regAddr_q;
        abortErr_d = abortErr_q;
        for (int i = RD_LAT - 1; i >= 1; i--) begin
            tagValid_d[i] = tagValid_q[i-1];
            tagLast_d[i]  = tagLast_q[i-1];
        end
        tagValid_d[0] = issue;
        tagLast_d[0]  = issue && (index_q == LAST_IDX);

        case (state_q)
            IDLE: begin
                if (done) begin
                    state_d    = ISSUE;
                    index_d    = '0;
                    abortErr_d = 1'b0;
                end
            end
            ISSUE: begin
                if (!done) begin
                    state_d    = IDLE;
                    abortErr_d = 1'b1;
                end else if (issue) begin
                    regAddr_d = 32'(index_q);
                    index_d   = index_q + IDX_W'(1);
                    if (index_q == LAST_IDX) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!done) begin
                    state_d    = IDLE;
                    abortErr_d = 1'b1;
                end else if ((inFlight == '0) && fifoEmpty) begin
                    state_d = HOLD;
                end
            end
            default: begin
                if (!done) begin
                    state_d = IDLE;
                end
            end
        endcase

        if (abortNow) begin
            tagValid_d = '0;
            tagLast_d  = '0;
        end
    end

    // FIFO bookkeeping; an abort flushes everything in one cycle.
    always_comb begin
        wrPtr_d   = push ? wrPtr_q + PTR_W'(1) : wrPtr_q;
        rdPtr_d   = pop ? rdPtr_q + PTR_W'(1) : rdPtr_q;
        lastMem_d = lastMem_q;
        if (push) begin
            lastMem_d[wrPtr_q] = tagLast_q[RD_LAT-1];
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (abortNow) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            index_q    <= '0;
            regAddr_q  <= '0;
            tagValid_q <= '0;
            tagLast_q  <= '0;
            lastMem_q  <= '0;
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            abortErr_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            index_q    <= index_d;
            regAddr_q  <= regAddr_d;
            tagValid_q <= tagValid_d;
            tagLast_q  <= tagLast_d;
            lastMem_q  <= lastMem_d;
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            count_q    <= count_d;
            abortErr_q <= abortErr_d;
        end
    end

    // FIFO payload storage needs no reset: it is only visible through
    // out_data when the occupancy count says the head entry is live.
    always_ff @(posedge clk) begin
        if (push) begin
            fifoMem_q[wrPtr_q] <= regData;
        end
    end

    always_comb begin
        out_valid = !fifoEmpty && !abortNow;
        out_data  = out_valid ? fifoMem_q[rdPtr_q] : '0;
        out_last  = out_valid && lastMem_q[rdPtr_q];
        busy      = (state_q == ISSUE) || (state_q == DRAIN);
        abort_err = abortErr_q;
        regAddr   = regAddr_q;
    end

endmodule
